// File: rtl/out_sync_pkg.sv
// ============================================================================
// out_sync_pkg
// Shared constants, state/source encodings and helpers for out_sync_arbiter_node.
// Revision: 1.0
// ============================================================================
`default_nettype none

package out_sync_pkg;

    localparam int OP_MSB = 11;
    localparam int OP_LSB = 8;

    localparam logic [3:0] REQ_OP_DEFAULT = 4'h2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SRC_P0   = 3'd0,
        SRC_P1   = 3'd1,
        SRC_P2   = 3'd2,
        SRC_P3   = 3'd3,
        SRC_TASK = 3'd4
    } src_e;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// rr_arbiter4
// Combinational 4-way arbiter: round-robin from ptr, or fixed order 1,0,2,3
// when OUT_SYNC_FIXED_PRIO_EN is defined. Masked requests never win.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4
    import out_sync_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [3:0] w_elig;
    logic [1:0] w_cand;

    assign w_elig = req & ~mask;

`ifdef OUT_SYNC_FIXED_PRIO_EN
    // Legacy order packed lowest-priority-last: 1, 0, 2, 3.
    localparam logic [7:0] c_fixed_order = {2'd3, 2'd2, 2'd0, 2'd1};

    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    always_comb begin
        gnt    = 4'b0000;
        idx    = 2'd0;
        any    = 1'b0;
        w_cand = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = c_fixed_order[2*k +: 2];
            if (!any && w_elig[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
                gnt = onehot4(w_cand);
            end
        end
    end
`else
    always_comb begin
        gnt    = 4'b0000;
        idx    = 2'd0;
        any    = 1'b0;
        w_cand = ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = ptr + 2'(k);
            if (!any && w_elig[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
                gnt = onehot4(w_cand);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/out_sync_arbiter_node.sv
// ============================================================================
// out_sync_arbiter_node
// Registered, handshaked arbiter for the node output word (peripherals over
// scheduler task). Optional macro: OUT_SYNC_FIXED_PRIO_EN (fixed priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_sync_arbiter_node
    import out_sync_pkg::*;
#(
    parameter logic [3:0] REQ_OP      = REQ_OP_DEFAULT,
    parameter int         STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  next_task,
    input  logic        next_task_valid,
    input  logic [15:0] peripheral0,
    input  logic [15:0] peripheral1,
    input  logic [15:0] peripheral2,
    input  logic [15:0] peripheral3,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        out_valid,
    output logic [3:0]  grant,
    output logic        next_task_ack,
    output logic        stall
);

    localparam int                 c_cnt_w   = $clog2(STALL_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STALL_LIMIT);

    state_e              state_q, state_d;
    src_e                src_q, src_d;
    logic [15:0]         out_q, out_d;
    logic [c_cnt_w-1:0]  stall_cnt_q, stall_cnt_d;
    logic                stall_q, stall_d;

    logic [15:0] w_periph [4];
    logic [3:0]  w_req;
    logic [3:0]  w_mask;
    logic [1:0]  w_ptr_eff;
    logic [3:0]  w_arb_gnt;
    logic [1:0]  w_arb_idx;
    logic        w_arb_any;
    logic        w_accept;
    logic        w_served_task;
    logic        w_served_periph;
    logic        w_task_ok;
    logic        w_arbitrate;

    assign w_periph[0] = peripheral0;
    assign w_periph[1] = peripheral1;
    assign w_periph[2] = peripheral2;
    assign w_periph[3] = peripheral3;

    always_comb begin
        w_req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_req[i] = (w_periph[i][OP_MSB:OP_LSB] == REQ_OP);
        end
    end

    // Reset gates the handshake so a word held across reset is never acknowledged.
    assign w_accept        = rst_n & (state_q == SEND) & out_ready;
    assign w_served_task   = w_accept & (src_q == SRC_TASK);
    assign w_served_periph = w_accept & (src_q != SRC_TASK);
    assign w_arbitrate     = (state_q == IDLE) | w_accept;

    // The served source still shows its request this cycle, so keep it out.
    assign w_mask    = w_served_periph ? onehot4(src_q[1:0]) : 4'b0000;
    assign w_task_ok = next_task_valid & ~w_served_task;

    assign grant         = w_served_periph ? onehot4(src_q[1:0]) : 4'b0000;
    assign next_task_ack = w_served_task;

`ifdef OUT_SYNC_FIXED_PRIO_EN
    assign w_ptr_eff = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign w_ptr_eff = w_served_periph ? (src_q[1:0] + 2'd1) : ptr_q;
    assign ptr_d     = w_ptr_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rr_arbiter4 u_arb (
        .req  (w_req),
        .mask (w_mask),
        .ptr  (w_ptr_eff),
        .gnt  (w_arb_gnt),
        .idx  (w_arb_idx),
        .any  (w_arb_any)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        out_d       = out_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;

        if (w_arbitrate) begin
            if (w_arb_any) begin
                state_d = SEND;
                src_d   = src_e'({1'b0, w_arb_idx});
                out_d   = w_periph[w_arb_idx];
            end else if (w_task_ok) begin
                state_d = SEND;
                src_d   = SRC_TASK;
                out_d   = {8'h00, next_task};
            end else begin
                state_d = IDLE;
            end
        end

        // Saturating count of consecutive unaccepted SEND cycles.
        if ((state_q == SEND) && !out_ready) begin
            if (stall_cnt_q != c_cnt_max) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (stall_cnt_q == (c_cnt_max - 1'b1)) begin
                stall_d = 1'b1;
            end
        end else begin
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= SRC_P0;
            out_q       <= 16'h0000;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            out_q       <= out_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    logic w_unused_grant_vec;
    assign w_unused_grant_vec = ^w_arb_gnt;

    assign out       = out_q;
    assign out_valid = (state_q == SEND);
    assign stall     = stall_q;

endmodule

`default_nettype wire

// File: doc/out_sync_arbiter_node.md
# out_sync_arbiter_node

Registered, handshaked arbiter for a node's 16-bit output word. Each cycle it selects one requesting peripheral word, or the scheduler's `next_task` when no peripheral requests. It holds the selected word stable until downstream accepts it, then returns a one-cycle grant to the served source. It sits between the node's peripheral response words and the node output bus, and replaces the purely combinational priority mux with fair, glitch-free sequencing.

## Interface
Parameters:
- `REQ_OP`, default 4'h2: op-field value in word bits [11:8] that marks a peripheral word as requesting output.
- `STALL_LIMIT`, default 16: number of consecutive unaccepted SEND cycles before `stall` is raised; legal range ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `next_task`  in  8  scheduler task word, layout [5:3] op, [2:0] task id.
- `next_task_valid`  in  1  `next_task` is offered.
- `peripheral0`..`peripheral3`  in  16 each  peripheral words; request when [11:8]==`REQ_OP`.
- `out_ready`  in  1  downstream accepts `out` this cycle.
- `out`  out  16  registered output word.
- `out_valid`  out  1  `out` holds a word.
- `grant`  out  4  one-hot, one-cycle acknowledge to the served peripheral.
- `next_task_ack`  out  1  one-cycle acknowledge that `next_task` was consumed.
- `stall`  out  1  sticky flag: SEND has been held `STALL_LIMIT` cycles.

## Operation
- States: IDLE (`out_valid`=0) and SEND (`out_valid`=1).
- Arbitration runs in IDLE, and in SEND on the accept cycle (`out_valid & out_ready`).
- Peripheral requests always beat `next_task`. `next_task` is taken only when no peripheral qualifies and `next_task_valid`=1.
- On a win, the word is snapshotted into `out`: a peripheral word verbatim; a task as {8'h00, `next_task`}. The source is recorded as P0–P3 or TASK. The state goes to SEND.
- SEND holds `out` and the source constant regardless of input changes.
- On accept, `grant[src]` or `next_task_ack` pulses in that same cycle. The next word is arbitrated in the same cycle, giving zero bubble. If nothing qualifies, the state goes to IDLE.
- Boundary rules:
  - On the accept cycle, the source just served is masked from arbitration, because the peripheral needs one cycle to drop its request.
  - If TASK was served, `next_task_valid` is ignored on that cycle.
- Round-robin: a pointer names the highest-priority peripheral. After a peripheral is served, the pointer moves to the next index modulo 4. Reset value is 0 (order 0,1,2,3). TASK wins do not move the pointer.
- Stall counter:
  - Counts consecutive SEND cycles with `out_ready`=0; clears on accept.
  - At `STALL_LIMIT`, `stall` is set and stays set until reset. The held word is unaffected.
  - The counter saturates and does not wrap.
- Reset mid-SEND discards the held word and issues no grant or ack.

## Timing
- Reset values: `out`=0, `out_valid`=0, `grant`=0, `next_task_ack`=0, `stall`=0, pointer=0, stall counter=0, state IDLE.
- Latency: a request sampled in IDLE at edge N gives `out`/`out_valid` valid after edge N.
- Throughput: one word per cycle while `out_ready`=1 and requests are present.
- `grant` and `next_task_ack` are combinational from state & `out_ready` and are never asserted simultaneously.
- `stall` rises at the edge completing the `STALL_LIMIT`-th waiting cycle.

## Configuration
- `OUT_SYNC_FIXED_PRIO_EN` defined: fixed peripheral priority 1,0,2,3 (legacy order). The pointer is removed; the accept-cycle mask still applies.
- Undefined (default): round-robin as above.
- Peripheral-over-task precedence is identical in both modes.

## Structure
- Package `out_sync_pkg` holds:
  - op-field bounds `OP_MSB`=11 and `OP_LSB`=8;
  - the default `REQ_OP`;
  - the state enum {IDLE, SEND};
  - the source enum {SRC_P0..SRC_P3, SRC_TASK}.
- Sub-module `rr_arbiter4`: 4-bit request and 4-bit mask in, pointer in, one-hot grant and index out. It is purely combinational and contains the macro-selected fixed/round-robin logic.
- The top level holds the FSM, snapshot register, pointer and stall counter.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all peripherals = 16'h02FF. Required: `out`=0, `out_valid`=0, `grant`=0 throughout.
- Single request: `peripheral2`=16'h0205, `out_ready`=1. Required: next cycle `out`=16'h0205, `out_valid`=1, `grant`=4'b0100 in that cycle.
- Fairness: all four peripherals request continuously, `out_ready`=1. Required: grants 0001,0010,0100,1000,0001. With `OUT_SYNC_FIXED_PRIO_EN`: 0010,0001,0010,0001.
- Task fallback: no requests, `next_task`=8'h2B valid. Required: `out`=16'h002B and `next_task_ack` pulses on accept. If `peripheral0` is raised during SEND, it is served next.
- Stall: `STALL_LIMIT`=16, `out_ready`=0 for 20 cycles while holding 16'h0211 and changing `peripheral1`. Required: `out` stays 16'h0211, `stall`=1 from cycle 16, and it stays set after accept.
- Reset in SEND: assert `rst_n`=0 while `out_valid`=1. Required: next cycle `out_valid`=0, no `grant`, pointer=0.
